// File: rtl/router_pkt_gen_if.sv
// Byte-stream link between the packet generator and the router input port.
// The generator drives data/valid; the router answers with busy.
interface router_pkt_gen_if;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       busy;

    modport master (
        output data_out,
        output pkt_valid,
        input  busy
    );

    modport slave (
        input  data_out,
        input  pkt_valid,
        output busy
    );
endinterface

// File: rtl/router_pkt_gen.sv
// Router traffic source: header, LFSR payload and parity byte per packet,
// holding each byte while the router reports busy.
module router_pkt_gen #(
    parameter int GAP_CYCLES = 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       dest_addr,
    input  logic [5:0]       payload_len,
    input  logic [7:0]       seed,
    input  logic             corrupt_parity,
    router_pkt_gen_if.master tx,
    output logic             tx_active,
    output logic             done,
    output logic             cmd_err,
    output logic [15:0]      pkt_count
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEADER  = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_PARITY  = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;

    localparam logic [3:0] GAP_LAST =
        4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [2:0]  r_state;
    logic [7:0]  r_header;
    logic [7:0]  r_lfsr;
    logic [7:0]  r_parity;
    logic        r_corrupt;
    logic [5:0]  r_len;
    logic [5:0]  r_rem;
    logic [3:0]  r_gap;
    logic        r_done;
    logic        r_cmd_err;
    logic [15:0] r_pkt_count;

    logic        w_consume;
    logic        w_illegal;
    logic [7:0]  w_lfsr_next;
    logic [7:0]  w_data;
    logic        w_valid;

    assign w_consume   = !tx.busy;
    assign w_illegal   = (dest_addr == 2'd3) || (payload_len == 6'd0);
    assign w_lfsr_next = {r_lfsr[6:0],
                          r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_header    <= 8'h00;
            r_lfsr      <= 8'h00;
            r_parity    <= 8'h00;
            r_corrupt   <= 1'b0;
            r_len       <= 6'd0;
            r_rem       <= 6'd0;
            r_gap       <= 4'd0;
            r_done      <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_pkt_count <= 16'd0;
        end else begin
            r_done    <= 1'b0;
            r_cmd_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_illegal) begin
                            r_cmd_err <= 1'b1;
                        end else begin
                            r_header  <= {payload_len, dest_addr};
                            r_parity  <= {payload_len, dest_addr};
                            r_lfsr    <= (seed == 8'h00) ? 8'h01 : seed;
                            r_len     <= payload_len;
                            r_corrupt <= corrupt_parity;
                            r_state   <= S_HEADER;
                        end
                    end
                end
                S_HEADER: begin
                    if (w_consume) begin
                        r_rem   <= r_len;
                        r_state <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (w_consume) begin
                        r_parity <= r_parity ^ r_lfsr;
                        r_lfsr   <= w_lfsr_next;
                        r_rem    <= r_rem - 6'd1;
                        if (r_rem == 6'd1)
                            r_state <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (w_consume) begin
                        r_done      <= 1'b1;
                        r_pkt_count <= r_pkt_count + 16'd1;
                        r_gap       <= GAP_LAST;
                        r_state     <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap == 4'd0)
                        r_state <= S_IDLE;
                    else
                        r_gap <= r_gap - 4'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from held registers, so a stall freezes them.
    always_comb begin
        w_data  = 8'h00;
        w_valid = 1'b0;
        case (r_state)
            S_HEADER: begin
                w_data  = r_header;
                w_valid = 1'b1;
            end
            S_PAYLOAD: begin
                w_data  = r_lfsr;
                w_valid = 1'b1;
            end
            S_PARITY: begin
                w_data  = r_parity ^ {7'd0, r_corrupt};
            end
            default: begin
                w_data  = 8'h00;
                w_valid = 1'b0;
            end
        endcase
    end

    assign tx.data_out  = w_data;
    assign tx.pkt_valid = w_valid;
    assign tx_active    = (r_state != S_IDLE);
    assign done         = r_done;
    assign cmd_err      = r_cmd_err;
    assign pkt_count    = r_pkt_count;
endmodule

// File: tb/tb_router_pkt_gen.sv
// Testbench for router_pkt_gen: queue-based packet model checked every
// cycle, plus directed byte sequences with literal expected values.
module tb_router_pkt_gen;
    localparam int GAP = 2;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [1:0]  dest_addr;
    logic [5:0]  payload_len;
    logic [7:0]  seed;
    logic        corrupt_parity;
    logic        tx_active;
    logic        done;
    logic        cmd_err;
    logic [15:0] pkt_count;

    router_pkt_gen_if bus ();

    router_pkt_gen #(.GAP_CYCLES(GAP)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .start          (start),
        .dest_addr      (dest_addr),
        .payload_len    (payload_len),
        .seed           (seed),
        .corrupt_parity (corrupt_parity),
        .tx             (bus),
        .tx_active      (tx_active),
        .done           (done),
        .cmd_err        (cmd_err),
        .pkt_count      (pkt_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Behavioural model: a packet is a queue of bytes still to be sent.
    typedef struct {
        logic [7:0] d;
        logic       v;
    } byte_t;

    byte_t       mq[$];
    int          m_gap   = 0;
    bit          m_done  = 0;
    bit          m_err   = 0;
    logic [15:0] m_count = 16'd0;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    task automatic build(input logic [1:0] d, input logic [5:0] n,
                         input logic [7:0] s, input logic c);
        logic [7:0] hdr, par, l;
        byte_t b;
        hdr = {n, d};
        par = hdr;
        l = (s == 8'h00) ? 8'h01 : s;
        mq.delete();
        b.d = hdr; b.v = 1'b1; mq.push_back(b);
        for (int i = 0; i < int'(n); i++) begin
            b.d = l; b.v = 1'b1; mq.push_back(b);
            par = par ^ l;
            l = lfsr_step(l);
        end
        b.d = par ^ {7'd0, c}; b.v = 1'b0; mq.push_back(b);
    endtask

    always @(posedge clock) begin
        if (!resetn) begin
            mq.delete();
            m_gap = 0; m_done = 0; m_err = 0; m_count = 16'd0;
        end else begin
            m_done = 0;
            m_err  = 0;
            if (mq.size() > 0) begin
                if (!bus.busy) begin
                    if (mq.size() == 1) begin
                        m_done = 1;
                        m_count = m_count + 16'd1;
                        m_gap = GAP;
                    end
                    void'(mq.pop_front());
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (start) begin
                if (dest_addr == 2'd3 || payload_len == 6'd0)
                    m_err = 1;
                else
                    build(dest_addr, payload_len, seed, corrupt_parity);
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            if (mq.size() > 0) begin
                check("m_data", {24'd0, bus.data_out}, {24'd0, mq[0].d});
                check("m_valid", {31'd0, bus.pkt_valid}, {31'd0, mq[0].v});
                check("m_active", {31'd0, tx_active}, 32'd1);
            end else begin
                check("m_data", {24'd0, bus.data_out}, 32'd0);
                check("m_valid", {31'd0, bus.pkt_valid}, 32'd0);
                check("m_active", {31'd0, tx_active}, {31'd0, m_gap > 0});
            end
            check("m_done", {31'd0, done}, {31'd0, m_done});
            check("m_cmd_err", {31'd0, cmd_err}, {31'd0, m_err});
            check("m_count", {16'd0, pkt_count}, {16'd0, m_count});
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_byte(input string nm, input logic [7:0] d,
                               input logic v);
        @(negedge clock);
        check({nm, "_data"}, {24'd0, bus.data_out}, {24'd0, d});
        check({nm, "_valid"}, {31'd0, bus.pkt_valid}, {31'd0, v});
        tick();
    endtask

    task automatic expect_done(input string nm, input logic [15:0] cnt);
        @(negedge clock);
        check({nm, "_done"}, {31'd0, done}, 32'd1);
        check({nm, "_count"}, {16'd0, pkt_count}, {16'd0, cnt});
        tick();
    endtask

    // Returns at the falling edge of an idle cycle.
    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!tx_active) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            failures++;
            $display("FAIL %s_idle_timeout actual=busy required=idle", nm);
        end
    endtask

    task automatic send(input logic [1:0] d, input logic [5:0] n,
                        input logic [7:0] s, input logic c);
        wait_idle("send");
        dest_addr = d; payload_len = n; seed = s; corrupt_parity = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n;
        bit found;
        resetn = 1'b0; start = 1'b0; dest_addr = 2'd0;
        payload_len = 6'd0; seed = 8'h00; corrupt_parity = 1'b0;
        bus.busy = 1'b0;
        repeat (2) tick();
        chk_en = 1'b1;
        @(negedge clock);
        check("rst_data", {24'd0, bus.data_out}, 32'd0);
        check("rst_valid", {31'd0, bus.pkt_valid}, 32'd0);
        check("rst_active", {31'd0, tx_active}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        check("rst_count", {16'd0, pkt_count}, 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        send(2'd1, 6'd3, 8'h5A, 1'b0);
        expect_byte("basic_hdr", 8'h0D, 1'b1);
        expect_byte("basic_p0", 8'h5A, 1'b1);
        expect_byte("basic_p1", 8'hB4, 1'b1);
        expect_byte("basic_p2", 8'h69, 1'b1);
        expect_byte("basic_par", 8'h8A, 1'b0);
        expect_done("basic", 16'd1);

        send(2'd1, 6'd3, 8'h5A, 1'b1);
        expect_byte("corr_hdr", 8'h0D, 1'b1);
        expect_byte("corr_p0", 8'h5A, 1'b1);
        expect_byte("corr_p1", 8'hB4, 1'b1);
        expect_byte("corr_p2", 8'h69, 1'b1);
        expect_byte("corr_par", 8'h8B, 1'b0);
        expect_done("corr", 16'd2);

        send(2'd1, 6'd3, 8'h5A, 1'b0);
        bus.busy = 1'b1;
        repeat (3) expect_byte("stall_hdr", 8'h0D, 1'b1);
        bus.busy = 1'b0;
        expect_byte("stall_hdr_go", 8'h0D, 1'b1);
        expect_byte("stall_p0", 8'h5A, 1'b1);
        bus.busy = 1'b1;
        repeat (2) expect_byte("stall_p1", 8'hB4, 1'b1);
        bus.busy = 1'b0;
        expect_byte("stall_p1_go", 8'hB4, 1'b1);
        expect_byte("stall_p2", 8'h69, 1'b1);
        expect_byte("stall_par", 8'h8A, 1'b0);
        expect_done("stall", 16'd3);

        send(2'd3, 6'd3, 8'h5A, 1'b0);
        @(negedge clock);
        check("ill_dest_err", {31'd0, cmd_err}, 32'd1);
        check("ill_dest_valid", {31'd0, bus.pkt_valid}, 32'd0);
        check("ill_dest_active", {31'd0, tx_active}, 32'd0);
        check("ill_dest_count", {16'd0, pkt_count}, 32'd3);
        tick();
        send(2'd0, 6'd0, 8'h5A, 1'b0);
        @(negedge clock);
        check("ill_len_err", {31'd0, cmd_err}, 32'd1);
        check("ill_len_active", {31'd0, tx_active}, 32'd0);
        check("ill_len_count", {16'd0, pkt_count}, 32'd3);
        tick();

        wait_idle("gap");
        dest_addr = 2'd0; payload_len = 6'd1; seed = 8'h00;
        corrupt_parity = 1'b0; start = 1'b1;
        tick();
        expect_byte("gap_hdr", 8'h04, 1'b1);
        expect_byte("gap_p0", 8'h01, 1'b1);
        expect_byte("gap_par", 8'h05, 1'b0);
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.pkt_valid && bus.data_out == 8'h04) begin
                found = 1'b1;
                break;
            end
            n++;
            tick();
        end
        start = 1'b0;
        check("gap_found", {31'd0, found}, 32'd1);
        check("gap_cycles", n, 32'd3);
        tick();

        send(2'd2, 6'd5, 8'h33, 1'b0);
        expect_byte("rst_hdr", 8'h16, 1'b1);
        expect_byte("rst_p0", 8'h33, 1'b1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clock);
        check("midrst_data", {24'd0, bus.data_out}, 32'd0);
        check("midrst_valid", {31'd0, bus.pkt_valid}, 32'd0);
        check("midrst_active", {31'd0, tx_active}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_count", {16'd0, pkt_count}, 32'd0);
        tick();

        send(2'd1, 6'd3, 8'h5A, 1'b0);
        expect_byte("clean_hdr", 8'h0D, 1'b1);
        expect_byte("clean_p0", 8'h5A, 1'b1);
        expect_byte("clean_p1", 8'hB4, 1'b1);
        expect_byte("clean_p2", 8'h69, 1'b1);
        expect_byte("clean_par", 8'h8A, 1'b0);
        expect_done("clean", 16'd1);
        wait_idle("end");

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/router_pkt_gen.md
# router_pkt_gen

Packet source that drives the router's input port: frames a header byte, an LFSR-generated payload and a trailing parity byte onto `data_out`/`pkt_valid`, and holds each byte while the router signals `busy`. It is the transmit-side counterpart of the router's input register stage. It is used as a synthesizable traffic generator for self-test and as a reference stimulus source. Parity matches the router's internal check, and a parity-corruption option exercises the router's error path.

## Interface
- `GAP_CYCLES`, default 2: idle cycles inserted after each packet's parity byte; legal range 0..15.
- `clock` input 1: rising-edge clock.
- `resetn` input 1: synchronous, active-low reset.
- `start` input 1: packet request, sampled only in IDLE.
- `dest_addr` input 2: destination port 0..2; 3 is illegal. Sampled with `start`.
- `payload_len` input 6: payload byte count 1..63; 0 is illegal. Sampled with `start`.
- `seed` input 8: LFSR seed, sampled with `start`; 8'h00 is replaced by 8'h01.
- `corrupt_parity` input 1: sampled with `start`; when set, the transmitted parity is XORed with 8'h01.
- `busy` input 1: router back-pressure. A presented byte is consumed only on an edge where `busy`=0.
- `pkt_valid` output 1: high while header and payload bytes are presented; low during the parity byte and idle.
- `data_out` output 8: current byte.
- `tx_active` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse after the parity byte is consumed.
- `cmd_err` output 1: one-cycle pulse when an illegal `start` is rejected.
- `pkt_count` output 16: count of completed packets; wraps from 16'hFFFF to 0.

## Operation
- States: IDLE, HEADER, PAYLOAD, PARITY, GAP.
- Reset values: state IDLE; `pkt_valid`=0, `data_out`=8'h00, `tx_active`=0, `done`=0, `cmd_err`=0, `pkt_count`=0; LFSR, parity and counters cleared.
- Reset mid-packet: the packet is abandoned with no `done` and no count increment. On the next cycle all outputs are at their reset values.
- IDLE, `start`=1 with a legal command:
  - Latch the command fields.
  - header = {payload_len, dest_addr}.
  - Parity accumulator = header.
  - LFSR = seed (or 8'h01 if the seed is 0).
  - Go to HEADER.
- IDLE, `start`=1 with `dest_addr`=3 or `payload_len`=0: pulse `cmd_err`, stay in IDLE, leave `pkt_count` unchanged.
- `start` outside IDLE is ignored. It is not queued.
- HEADER: present header with `pkt_valid`=1. On consumption, go to PAYLOAD with remaining count = `payload_len`.
- PAYLOAD: present the current LFSR value with `pkt_valid`=1. On consumption:
  - parity ^= byte;
  - LFSR advances: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]};
  - remaining is decremented.
  - After the last byte, go to PARITY.
- PARITY: present parity (XOR of header and all payload bytes, ^8'h01 if corrupt) with `pkt_valid`=0. On consumption:
  - pulse `done` in the next cycle;
  - increment `pkt_count`;
  - go to GAP, or to IDLE if `GAP_CYCLES`=0.
- GAP: `pkt_valid`=0, `data_out`=8'h00 for `GAP_CYCLES` cycles, then IDLE.
- Stall behaviour: while `busy`=1, `data_out`, `pkt_valid`, the LFSR, parity and remaining count all hold. `pkt_valid` never drops mid-packet because of a stall.

## Timing
- Start latency: `start` sampled at edge E puts the header on `data_out` in the cycle after E.
- Throughput: with `busy`=0, one byte per cycle. A packet occupies `payload_len`+2 cycles.
- `done` is high in the cycle following the parity-consumption edge. `pkt_count` updates on that same edge.
- Back-to-back packets: with `start` held high, there are `GAP_CYCLES`+1 non-header cycles between the parity byte's last cycle and the next header.
- `cmd_err` is high in the cycle after the rejected `start` edge.

## Test plan
- Basic packet:
  - Stimulus: dest 1, len 3, seed 8'h5A, `busy`=0.
  - Required: header 8'h0D, payload 8'h5A, 8'hB4, 8'h69, parity 8'h8A with `pkt_valid`=0.
  - Required: `done` pulses once and `pkt_count`=1.
- Corrupt parity: same command with `corrupt_parity`=1 -> parity byte 8'h8B; all other bytes identical.
- Stall:
  - Hold `busy`=1 for 3 cycles during the header and 2 cycles during the second payload byte.
  - Required: each byte is held stable with `pkt_valid`=1, the byte sequence is unchanged, and the total length is 10 cycles.
- Illegal commands: dest 3, or len 0 -> `cmd_err` pulse, `pkt_valid` stays 0, `tx_active` stays 0, `pkt_count` unchanged.
- Zero seed and gap:
  - Stimulus: dest 0, len 1, seed 0, `start` held high, `GAP_CYCLES`=2.
  - Required: bytes 8'h04, 8'h01, 8'h05, then 3 non-header cycles before the next 8'h04 header.
- Reset mid-payload:
  - Drive `resetn`=0 during the second payload byte.
  - Required: the next cycle has all outputs at 0, no `done`, `pkt_count` 0.
  - Required: a new `start` then produces a clean packet.
